matrix_stack: RTL

MATRIX_STACK -- requirements
Module: matrix_stack

---
 rtl/matrix_pkg.sv | 45 ++++
 rtl/matrix_stack_bank.sv | 55 +++++
 rtl/matrix_stack.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix stack.
//   - command encodings (cmd_e), FSM state encoding (state_e)
//   - IEEE-754 single-precision 1.0 and the four identity rows for a
//     default-width (4 x 32-bit float) row, plus a row lookup helper
package matrix_pkg;

    localparam int DEFAULT_ROW_W = 128;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

    // Element c of a row lives at bits [c*32 +: 32]; row r has 1.0 at column r.
    localparam logic [127:0] ID_ROW0 = {96'h0, FP_ONE};
    localparam logic [127:0] ID_ROW1 = {64'h0, FP_ONE, 32'h0};
    localparam logic [127:0] ID_ROW2 = {32'h0, FP_ONE, 64'h0};
    localparam logic [127:0] ID_ROW3 = {FP_ONE, 96'h0};

    // Codes 6 and 7 are not listed and behave as NOP.
    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_LOAD    = 3'd1,
        CMD_LOAD_ID = 3'd2,
        CMD_PUSH    = 3'd3,
        CMD_POP     = 3'd4,
        CMD_WRITE   = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD0 = 3'd1,
        ST_LOAD1 = 3'd2,
        ST_LOAD2 = 3'd3,
        ST_LOAD3 = 3'd4
    } state_e;

    function automatic logic [127:0] id_row(input int r);
        case (r)
            0:       return ID_ROW0;
            1:       return ID_ROW1;
            2:       return ID_ROW2;
            3:       return ID_ROW3;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/matrix_stack_bank.sv
// matrix_stack_bank: storage and stack pointer for one matrix stack.
//   clk, reset      : clock, synchronous active-high reset
//   i_write_en      : overwrite the top matrix with i_write_data
//   i_push          : copy top to sp+1 and increment sp (ignored when full)
//   i_pop           : decrement sp (ignored when sp==0)
//   o_peek          : current top matrix (combinational)
//   o_sp            : current stack pointer
// Every slot is reset (slot 0 to identity), so storage is register based.
module matrix_stack_bank
    import matrix_pkg::*;
#(
    parameter int                 ROW_W    = DEFAULT_ROW_W,
    parameter int                 DEPTH    = 8,
    parameter logic [4*ROW_W-1:0] IDENTITY = '0,
    localparam int                SP_W     = $clog2(DEPTH),
    localparam int                MAT_W    = 4 * ROW_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_write_en,
    input  logic [MAT_W-1:0] i_write_data,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [MAT_W-1:0] o_peek,
    output logic [SP_W-1:0]  o_sp
);

    logic [MAT_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;

    assign o_peek = r_mem[r_sp];
    assign o_sp   = r_sp;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= (i == 0) ? IDENTITY : '0;
            end
            r_sp <= '0;
        end else begin
            if (i_push && (r_sp != SP_W'(DEPTH - 1))) begin
                r_mem[r_sp + SP_W'(1)] <= r_mem[r_sp];
                r_sp                   <= r_sp + SP_W'(1);
            end else if (i_pop && (r_sp != '0)) begin
                r_sp <= r_sp - SP_W'(1);
            end
            // Writes never coincide with push/pop (different commands),
            // so indexing with the current sp is safe.
            if (i_write_en) begin
                r_mem[r_sp] <= i_write_data;
            end
        end
    end

endmodule

// File: rtl/matrix_stack.sv
// matrix_stack: NUM_STACKS independent matrix stacks with a 4-beat LOAD path.
//   clk, reset                  : clock, synchronous active-high reset
//   fifo_full                   : downstream backpressure, stalls commands and beats
//   matrix_mode                 : stack selected for commands and peek
//   cmd_valid/cmd/cmd_ready     : command handshake
//   data_valid/data_in          : LOAD row beats, row 0 first
//   write_in                    : matrix for WRITE, row r at [r*ROW_W +: ROW_W]
//   peek_out/depth_out          : top matrix and sp of the selected stack
//   busy                        : LOAD in progress
//   err_overflow/err_underflow  : one-cycle pulses for rejected PUSH/POP
module matrix_stack
    import matrix_pkg::*;
#(
    parameter int  ROW_W      = DEFAULT_ROW_W,
    parameter int  DEPTH      = 8,
    parameter int  NUM_STACKS = 2,
    localparam int MODE_W     = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1,
    localparam int SP_W       = $clog2(DEPTH),
    localparam int MAT_W      = 4 * ROW_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_full,
    input  logic [MODE_W-1:0] matrix_mode,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    output logic              cmd_ready,
    input  logic              data_valid,
    input  logic [ROW_W-1:0]  data_in,
    input  logic [MAT_W-1:0]  write_in,
    output logic [MAT_W-1:0]  peek_out,
    output logic [SP_W-1:0]   depth_out,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_underflow
);

    function automatic logic [MAT_W-1:0] build_identity();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int r = 0; r < 4; r++) begin
            m[r*ROW_W +: ROW_W] = ROW_W'(id_row(r));
        end
        return m;
    endfunction

    localparam logic [MAT_W-1:0] IDENTITY = build_identity();

    state_e            r_state;
    logic [ROW_W-1:0]  r_shadow [3];
    logic [MODE_W-1:0] r_load_mode;
    logic              r_err_ovf;
    logic              r_err_unf;

    logic              w_accept;
    logic              w_beat;
    logic              w_commit;
    logic              w_sel_hit;
    logic [MAT_W-1:0]  w_wr_data;
    logic [MAT_W-1:0]  w_peek [NUM_STACKS];
    logic [SP_W-1:0]   w_sp   [NUM_STACKS];

    assign cmd_ready     = (r_state == ST_IDLE) && !fifo_full;
    assign busy          = (r_state != ST_IDLE);
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_beat   = data_valid && !fifo_full;
    // Row 3 goes straight from data_in so all four rows land in one edge.
    assign w_commit = (r_state == ST_LOAD3) && w_beat;

    // Commands are only accepted in IDLE and commits only happen in LOAD3,
    // so one shared write-data bus serves every bank.
    always_comb begin
        w_wr_data = write_in;
        if (w_commit) begin
            w_wr_data = {data_in, r_shadow[2], r_shadow[1], r_shadow[0]};
        end else if (cmd == CMD_LOAD_ID) begin
            w_wr_data = IDENTITY;
        end
    end

    for (genvar gi = 0; gi < NUM_STACKS; gi++) begin : g_bank
        logic w_hit;
        logic w_wr_en;
        logic w_push;
        logic w_pop;

        assign w_hit   = (matrix_mode == MODE_W'(gi));
        assign w_wr_en = (w_accept && w_hit &&
                          ((cmd == CMD_WRITE) || (cmd == CMD_LOAD_ID))) ||
                         (w_commit && (r_load_mode == MODE_W'(gi)));
        assign w_push  = w_accept && w_hit && (cmd == CMD_PUSH);
        assign w_pop   = w_accept && w_hit && (cmd == CMD_POP);

        matrix_stack_bank #(
            .ROW_W    (ROW_W),
            .DEPTH    (DEPTH),
            .IDENTITY (IDENTITY)
        ) u_bank (
            .clk          (clk),
            .reset        (reset),
            .i_write_en   (w_wr_en),
            .i_write_data (w_wr_data),
            .i_push       (w_push),
            .i_pop        (w_pop),
            .o_peek       (w_peek[gi]),
            .o_sp         (w_sp[gi])
        );
    end

    // A mode value with no stack behind it reads as zero and never errors.
    always_comb begin
        peek_out  = '0;
        depth_out = '0;
        w_sel_hit = 1'b0;
        for (int i = 0; i < NUM_STACKS; i++) begin
            if (matrix_mode == MODE_W'(i)) begin
                peek_out  = w_peek[i];
                depth_out = w_sp[i];
                w_sel_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_load_mode <= '0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_err_ovf <= w_accept && w_sel_hit && (cmd == CMD_PUSH) &&
                         (depth_out == SP_W'(DEPTH - 1));
            r_err_unf <= w_accept && w_sel_hit && (cmd == CMD_POP) &&
                         (depth_out == '0);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (cmd == CMD_LOAD)) begin
                        r_state     <= ST_LOAD0;
                        r_load_mode <= matrix_mode;
                    end
                end
                ST_LOAD0: begin
                    if (w_beat) begin
                        r_shadow[0] <= data_in;
                        r_state     <= ST_LOAD1;
                    end
                end
                ST_LOAD1: begin
                    if (w_beat) begin
                        r_shadow[1] <= data_in;
                        r_state     <= ST_LOAD2;
                    end
                end
                ST_LOAD2: begin
                    if (w_beat) begin
                        r_shadow[2] <= data_in;
                        r_state     <= ST_LOAD3;
                    end
                end
                ST_LOAD3: begin
                    if (w_beat) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
